// File: rtl/ws_timing_pkg.sv
// Shared WS2812B timing constants, select encodings and timer state encoding.
// The bit serialiser reuses the default interval counts from here.
package ws_timing_pkg;

    localparam int CNT_W_DEF   = 13;
    localparam int RET_CNT_DEF = 6000;
    localparam int T0H_CNT_DEF = 40;
    localparam int T0L_CNT_DEF = 85;
    localparam int T1H_CNT_DEF = 80;
    localparam int T1L_CNT_DEF = 45;

    localparam logic [2:0] SEL_RET = 3'd0;
    localparam logic [2:0] SEL_T0H = 3'd1;
    localparam logic [2:0] SEL_T0L = 3'd2;
    localparam logic [2:0] SEL_T1H = 3'd3;
    localparam logic [2:0] SEL_T1L = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/ws_dur_lut.sv
// Combinational interval lookup: sel -> (N-1) load value and legality flag.
// Load values are N-1 truncated to CNT_W bits, so N = 2^CNT_W still fits.
module ws_dur_lut
    import ws_timing_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int RET_CNT = RET_CNT_DEF,
    parameter int T0H_CNT = T0H_CNT_DEF,
    parameter int T0L_CNT = T0L_CNT_DEF,
    parameter int T1H_CNT = T1H_CNT_DEF,
    parameter int T1L_CNT = T1L_CNT_DEF
) (
    input  logic [2:0]       sel,
    output logic [CNT_W-1:0] load,
    output logic             legal
);

    localparam logic [CNT_W-1:0] RET_LD = CNT_W'(RET_CNT - 1);
    localparam logic [CNT_W-1:0] T0H_LD = CNT_W'(T0H_CNT - 1);
    localparam logic [CNT_W-1:0] T0L_LD = CNT_W'(T0L_CNT - 1);
    localparam logic [CNT_W-1:0] T1H_LD = CNT_W'(T1H_CNT - 1);
    localparam logic [CNT_W-1:0] T1L_LD = CNT_W'(T1L_CNT - 1);

    always_comb begin
        load  = '0;
        legal = 1'b1;
        case (sel)
            SEL_RET: load = RET_LD;
            SEL_T0H: load = T0H_LD;
            SEL_T0L: load = T0L_LD;
            SEL_T1H: load = T1H_LD;
            SEL_T1L: load = T1L_LD;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ws_interval_timer.sv
// One-shot / auto-reload down-counter producing every WS2812B protocol interval.
// Reload at expiry happens on the done edge itself, so back-to-back phases abut.
module ws_interval_timer
    import ws_timing_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int RET_CNT = RET_CNT_DEF,
    parameter int T0H_CNT = T0H_CNT_DEF,
    parameter int T0L_CNT = T0L_CNT_DEF,
    parameter int T1H_CNT = T1H_CNT_DEF,
    parameter int T1L_CNT = T1L_CNT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       sel,
    input  logic             auto_reload,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             start_err,
    output logic [2:0]       sel_q,
    output logic [CNT_W-1:0] remaining
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       sel_lat_q, sel_lat_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] new_load, cur_load;
    logic             new_legal, cur_legal_unused;

    // New request and the currently latched interval are looked up in parallel
    // so an auto-reload never waits on the start path.
    ws_dur_lut #(
        .CNT_W(CNT_W), .RET_CNT(RET_CNT), .T0H_CNT(T0H_CNT),
        .T0L_CNT(T0L_CNT), .T1H_CNT(T1H_CNT), .T1L_CNT(T1L_CNT)
    ) u_lut_new (
        .sel   (sel),
        .load  (new_load),
        .legal (new_legal)
    );

    ws_dur_lut #(
        .CNT_W(CNT_W), .RET_CNT(RET_CNT), .T0H_CNT(T0H_CNT),
        .T0L_CNT(T0L_CNT), .T1H_CNT(T1H_CNT), .T1L_CNT(T1L_CNT)
    ) u_lut_cur (
        .sel   (sel_lat_q),
        .load  (cur_load),
        .legal (cur_legal_unused)
    );

    logic expire;
    assign expire = (state_q == ST_RUN) && (rem_q == '0);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        sel_lat_d = sel_lat_q;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !new_legal) begin
                    err_d = 1'b1;
                end else if (start && !abort) begin
                    state_d   = ST_RUN;
                    sel_lat_d = sel;
                    rem_d     = new_load;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                    err_d   = start && (!new_legal || !expire);
                end else if (expire) begin
                    if (start && new_legal) begin
                        sel_lat_d = sel;
                        rem_d     = new_load;
                    end else begin
                        err_d = start;
                        if (auto_reload) begin
                            rem_d = cur_load;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    // Mid-interval starts never disturb the running count.
                    err_d = start;
                    rem_d = rem_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            sel_lat_q <= SEL_RET;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            sel_lat_q <= sel_lat_d;
            err_q     <= err_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = expire;
    assign start_err = err_q;
    assign sel_q     = sel_lat_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_ws_interval_timer.sv
// Bench for ws_interval_timer: expected done cycles are queued at start time
// and popped by a negedge monitor; state is checked directly between edges.
module tb_ws_interval_timer;

    localparam int CNT_W = 13;

    logic clk = 1'b0;
    logic reset;
    logic start, auto_reload, abort;
    logic [2:0] sel;
    logic busy, done, start_err;
    logic [2:0] sel_q;
    logic [CNT_W-1:0] remaining;

    logic start1, auto_reload1, abort1;
    logic [2:0] sel1;
    logic busy1, done1, start_err1;
    logic [2:0] sel_q1;
    logic [CNT_W-1:0] remaining1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws_interval_timer u_dut (
        .clk(clk), .reset(reset), .start(start), .sel(sel),
        .auto_reload(auto_reload), .abort(abort), .busy(busy), .done(done),
        .start_err(start_err), .sel_q(sel_q), .remaining(remaining)
    );

    ws_interval_timer #(.T0H_CNT(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .sel(sel1),
        .auto_reload(auto_reload1), .abort(abort1), .busy(busy1), .done(done1),
        .start_err(start_err1), .sel_q(sel_q1), .remaining(remaining1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a one-cycle start; if n > 0 queue the cycle where done must appear.
    task automatic pulse_start(input logic [2:0] s, input int n);
        start = 1'b1;
        sel   = s;
        if (n > 0) exp_q.push_back(32'(cyc + n));
        tick(1);
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) check("done_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            else check("done_cycle", 32'(cyc), exp_q.pop_front());
        end
    end

    initial begin
        reset = 1'b0; start = 1'b0; sel = 3'd0; auto_reload = 1'b0; abort = 1'b0;
        start1 = 1'b0; sel1 = 3'd0; auto_reload1 = 1'b0; abort1 = 1'b0;

        tick(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", start_err, 0);
        check("rst_sel_q", sel_q, 0);
        check("rst_rem", remaining, 0);
        reset = 1'b1;
        tick(2);

        // 1: RET one-shot
        pulse_start(3'd0, 6000);
        check("ret_busy0", busy, 1);
        check("ret_rem0", remaining, 5999);
        tick(5999);
        check("ret_last_rem", remaining, 0);
        check("ret_last_busy", busy, 1);
        check("ret_last_done", done, 1);
        tick(1);
        check("ret_idle_busy", busy, 0);
        check("ret_idle_rem", remaining, 0);
        tick(2);

        // 2: T0H auto-reload for three periods
        auto_reload = 1'b1;
        exp_q.push_back(32'(cyc + 40));
        exp_q.push_back(32'(cyc + 80));
        pulse_start(3'd1, 120);
        for (int i = 0; i < 120; i++) begin
            check("ar_rem", remaining, 32'(39 - (i % 40)));
            check("ar_busy", busy, 1);
            if (i == 100) auto_reload = 1'b0;
            tick(1);
        end
        check("ar_stop_busy", busy, 0);
        tick(2);

        // 3: rejected mid-run start, then start in the done cycle
        pulse_start(3'd1, 40);
        tick(19);
        check("mid_rem20", remaining, 20);
        pulse_start(3'd3, 0);
        check("mid_err", start_err, 1);
        check("mid_rem19", remaining, 19);
        check("mid_sel_q", sel_q, 1);
        tick(1);
        check("mid_err_clr", start_err, 0);
        tick(18);
        check("mid_done", done, 1);
        pulse_start(3'd4, 45);
        check("rl_rem", remaining, 44);
        check("rl_sel_q", sel_q, 4);
        check("rl_busy", busy, 1);
        check("rl_err", start_err, 0);
        tick(44);
        check("rl_done", done, 1);
        tick(1);
        check("rl_idle", busy, 0);
        tick(2);

        // 4: abort mid-RET, then abort beating start in IDLE
        pulse_start(3'd0, 0);
        tick(5899);
        check("ab_rem100", remaining, 100);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_rem", remaining, 0);
        abort = 1'b1;
        pulse_start(3'd1, 0);
        abort = 1'b0;
        check("ab_start_busy", busy, 0);
        tick(3);
        check("ab_start_busy2", busy, 0);

        // 5: illegal select, then async reset mid-interval
        pulse_start(3'd6, 0);
        check("ill_err", start_err, 1);
        check("ill_busy", busy, 0);
        tick(1);
        check("ill_err_clr", start_err, 0);
        pulse_start(3'd2, 0);
        tick(30);
        check("ar_pre_sel_q", sel_q, 2);
        #2 reset = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_rem", remaining, 0);
        check("async_sel_q", sel_q, 0);
        check("async_done", done, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick(100);
        check("async_after_busy", busy, 0);

        // 6: N=1 instance
        start1 = 1'b1; sel1 = 3'd1;
        tick(1);
        start1 = 1'b0;
        check("n1_busy", busy1, 1);
        check("n1_done", done1, 1);
        check("n1_rem", remaining1, 0);
        tick(1);
        check("n1_idle_busy", busy1, 0);
        check("n1_idle_done", done1, 0);
        auto_reload1 = 1'b1;
        start1 = 1'b1; sel1 = 3'd1;
        tick(1);
        start1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("n1_ar_done", done1, 1);
            check("n1_ar_busy", busy1, 1);
            tick(1);
        end
        auto_reload1 = 1'b0;
        tick(1);
        check("n1_ar_stop", done1, 0);

        tick(2);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
